// File: rtl/ram_dual_port_param.sv
// Simple dual-port RAM with byte enables, write-first bypass and a post-reset zeroing sweep.
// Read latency 1 edge (2 with RAM_OUT_REG_EN); no backpressure, accepts a read and a write every cycle in RUN.
module ram_dual_port_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
    end else if (state == ST_INIT) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == {ADDR_W{1'b1}})
        state <= ST_RUN;
    end
  end

  assign init_done = (state == ST_RUN);

  // Memory is not reset; while rst is held the sweep harmlessly rewrites word 0.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++)
        if (wr_be[i])
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Write-first: lanes being written this edge at the read address return the new data.
  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < NB; i++)
      if (wr_en && wr_be[i] && (wr_addr == rd_addr))
        rd_word[8*i +: 8] = wr_data[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (state == ST_RUN) begin
      rd_valid_q <= rd_en;
      if (rd_en)
        rd_data_q <= rd_word;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] rd_data_q2;
  logic              rd_valid_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q2  <= '0;
      rd_valid_q2 <= 1'b0;
    end else if (state == ST_RUN) begin
      rd_valid_q2 <= rd_valid_q;
      if (rd_valid_q)
        rd_data_q2 <= rd_data_q;
    end else begin
      rd_data_q2  <= '0;
      rd_valid_q2 <= 1'b0;
    end
  end

  assign rd_data  = rd_data_q2;
  assign rd_valid = rd_valid_q2;
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_ram_dual_port_param.sv
// Directed bench for ram_dual_port_param (DATA_W=16, ADDR_W=2), both read-latency builds.
module tb_ram_dual_port_param;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        init_done;

  int checks = 0;
  int failures = 0;

  ram_dual_port_param #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [1:0] be, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic do_read(input string tag, input logic [1:0] a, input logic [15:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    check({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
    check({tag, "_dat"}, {16'b0, rd_data}, {16'b0, exp});
  endtask

  logic [15:0] exp_mem [4];

  initial begin
    #2;
    check("rst_rd_data", {16'b0, rd_data}, 32'h0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);

    // Release reset while hammering both ports; INIT must ignore them.
    @(posedge clk); #1;
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_be = 2'b11; wr_data = 16'hFFFF;
    rd_en = 1'b1; rd_addr = 2'd1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("init_vld_e%0d", e), {31'b0, rd_valid}, 32'd0);
      check($sformatf("init_done_e%0d", e), {31'b0, init_done}, (e == 4) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;

    for (int a = 0; a < 4; a++)
      do_read($sformatf("zero_a%0d", a), 2'(a), 16'h0000);

    tick();
    check("vld_drop", {31'b0, rd_valid}, 32'd0);
    check("dat_hold", {16'b0, rd_data}, 32'h0);

    do_write(2'd2, 2'b11, 16'hA55A);
    do_read("full_wr", 2'd2, 16'hA55A);

    do_write(2'd2, 2'b01, 16'h1234);
    do_read("byte_wr", 2'd2, 16'hA534);

    do_write(2'd3, 2'b00, 16'hDEAD);
    do_read("be_zero", 2'd3, 16'h0000);

    // Same-edge collision: only the upper lane is written.
    wr_en = 1'b1; wr_addr = 2'd1; wr_be = 2'b10; wr_data = 16'hBEEF;
    rd_en = 1'b1; rd_addr = 2'd1;
    tick();
    wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    check("coll_vld", {31'b0, rd_valid}, 32'd1);
    check("coll_dat", {16'b0, rd_data}, 32'hBE00);

    // Different addresses on the same edge are independent.
    wr_en = 1'b1; wr_addr = 2'd3; wr_be = 2'b11; wr_data = 16'h1111;
    rd_en = 1'b1; rd_addr = 2'd2;
    tick();
    wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    check("indep_dat", {16'b0, rd_data}, 32'hA534);

    exp_mem[0] = 16'h0000; exp_mem[1] = 16'hBE00;
    exp_mem[2] = 16'hA534; exp_mem[3] = 16'h1111;
    for (int k = 0; k < 4 + LAT - 1; k++) begin
      rd_en = (k < 4); rd_addr = 2'(k);
      tick();
      if (k >= LAT - 1) begin
        check($sformatf("b2b_vld%0d", k - LAT + 1), {31'b0, rd_valid}, 32'd1);
        check($sformatf("b2b_dat%0d", k - LAT + 1), {16'b0, rd_data}, {16'b0, exp_mem[k - LAT + 1]});
      end
    end
    rd_en = 1'b0;

    // Reset right after a read edge drops the in-flight result.
    rd_en = 1'b1; rd_addr = 2'd2;
    tick();
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'b0, rd_valid}, 32'd0);
    check("mid_rst_done", {31'b0, init_done}, 32'd0);
    check("mid_rst_dat", {16'b0, rd_data}, 32'h0);
    tick();
    check("mid_rst_vld2", {31'b0, rd_valid}, 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("re_vld_e%0d", e), {31'b0, rd_valid}, 32'd0);
      check($sformatf("re_done_e%0d", e), {31'b0, init_done}, (e == 4) ? 32'd1 : 32'd0);
    end
    do_read("re_zero_a2", 2'd2, 16'h0000);
    do_read("re_zero_a1", 2'd1, 16'h0000);
    do_read("re_zero_a3", 2'd3, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
